// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment display path.
package seg_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StShow,
    StBlank
  } scan_state_e;

  // Segment patterns, bit order {g,f,e,d,c,b,a}, active-high (common cathode).
  localparam logic [6:0] SegBlank = 7'h00;
  localparam logic [6:0] SegF     = 7'h71;

  // Reference decode used by the shared decoder one level up; nibbles above 9 show "F".
  function automatic logic [6:0] bcd_to_seg(input logic [DIGIT_W-1:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = 7'h3f;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5b;
      4'd3:    seg = 7'h4f;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6d;
      4'd6:    seg = 7'h7d;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7f;
      4'd9:    seg = 7'h6f;
      default: seg = SegF;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_lz_mask.sv
// Leading-zero blank mask: a digit is blanked while it and every more-significant
// digit are zero with no decimal point requested. Digit 0 always stays lit.
module seg_lz_mask
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic [DIGIT_W*NUM_DIGITS-1:0] active_i,
  input  logic                          lz_blank_i,
  input  logic [NUM_DIGITS-1:0]         dp_mask_i,
  output logic [NUM_DIGITS-1:0]         blank_mask_o
);

  // Walk from the most-significant digit down; once anything significant is seen, stop blanking.
  always_comb begin
    logic keep;
    keep         = 1'b0;
    blank_mask_o = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      keep = keep | (active_i[i*DIGIT_W +: DIGIT_W] != '0) | dp_mask_i[i];
      blank_mask_o[i] = lz_blank_i & ~keep & (i != 0);
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Digit scan controller: shows one frame-stable BCD nibble at a time with a
// dead-time between digits, driving one-hot digit enables for a shared decoder.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ena,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] value_in,
  input  logic                          value_valid,
  input  logic                          lz_blank,
  input  logic [NUM_DIGITS-1:0]         dp_mask,
  output logic [DIGIT_W-1:0]            bcd_out,
  output logic                          dp_out,
  output logic [NUM_DIGITS-1:0]         digit_en,
  output logic                          frame_start
);

  localparam int unsigned ValW     = DIGIT_W * NUM_DIGITS;
  localparam int unsigned IdxW     = $clog2(NUM_DIGITS);
  localparam int unsigned PrescMax = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int unsigned PrescW   = ($clog2(PrescMax) > 0) ? $clog2(PrescMax) : 1;

  localparam logic [PrescW-1:0] ShowLast  = PrescW'(SCAN_DIV - 1);
  // BLANK is unreachable when BLANK_CYCLES is 0, so its terminal count is a don't-care there.
  localparam logic [PrescW-1:0] BlankLast = PrescW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IdxW-1:0]   IdxLast   = IdxW'(NUM_DIGITS - 1);

  scan_state_e             state_q, state_d;
  logic [IdxW-1:0]         idx_q, idx_d, idx_nxt;
  logic [PrescW-1:0]       presc_q, presc_d;
  logic [ValW-1:0]         pending_q, pending_d;
  logic [ValW-1:0]         active_q, active_d;
  logic                    pend_q, pend_d;
  logic                    boundary;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [DIGIT_W-1:0]      bcd_q, bcd_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   en_q, en_d;
  logic                    fs_q, fs_d;

  assign idx_nxt = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;

  // Next-state: scan sequencing, prescaler, and frame-boundary snapshot of the value.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    presc_d   = presc_q;
    pending_d = pending_q;
    pend_d    = pend_q;
    active_d  = active_q;
    boundary  = 1'b0;

    if (value_valid) begin
      pending_d = value_in;
      pend_d    = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (ena) begin
          state_d  = StShow;
          idx_d    = '0;
          presc_d  = '0;
          boundary = 1'b1;
        end
      end
      StShow: begin
        if (presc_q == ShowLast) begin
          presc_d = '0;
          if (BLANK_CYCLES != 0) begin
            state_d = StBlank;
          end else begin
            idx_d    = idx_nxt;
            boundary = (idx_nxt == '0);
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      StBlank: begin
        if (presc_q == BlankLast) begin
          state_d  = StShow;
          presc_d  = '0;
          idx_d    = idx_nxt;
          boundary = (idx_nxt == '0);
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (!ena) begin
      state_d  = StIdle;
      idx_d    = '0;
      presc_d  = '0;
      boundary = 1'b0;
    end

    // A strobe in the boundary cycle bypasses pending so it lands in this frame.
    if (boundary) begin
      if (value_valid) begin
        active_d = value_in;
      end else if (pend_q) begin
        active_d = pending_q;
      end
      pend_d = 1'b0;
    end
  end

  seg_lz_mask #(
    .NUM_DIGITS(NUM_DIGITS)
  ) u_lz_mask (
    .active_i    (active_d),
    .lz_blank_i  (lz_blank),
    .dp_mask_i   (dp_mask),
    .blank_mask_o(blank_mask)
  );

  // Output next-values are derived from the next state so the registered outputs line up with it.
  always_comb begin
    bcd_d = bcd_q;
    dp_d  = 1'b0;
    en_d  = '0;
    fs_d  = 1'b0;
    unique case (state_d)
      StShow: begin
        bcd_d = active_d[idx_d*DIGIT_W +: DIGIT_W];
        fs_d  = boundary;
        if (!blank_mask[idx_d]) begin
          en_d = NUM_DIGITS'(1) << idx_d;
          dp_d = dp_mask[idx_d];
        end
      end
      StBlank: bcd_d = bcd_q;
      default: bcd_d = '0;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      presc_q   <= '0;
      pending_q <= '0;
      active_q  <= '0;
      pend_q    <= 1'b0;
      bcd_q     <= '0;
      dp_q      <= 1'b0;
      en_q      <= '0;
      fs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      presc_q   <= presc_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      pend_q    <= pend_d;
      bcd_q     <= bcd_d;
      dp_q      <= dp_d;
      en_q      <= en_d;
      fs_q      <= fs_d;
    end
  end

  assign bcd_out     = bcd_q;
  assign dp_out      = dp_q;
  assign digit_en    = en_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: two instances (with and without dead-time) share stimulus;
// a frame-position reference model queues expected outputs, a monitor pops and compares.
module tb_seg_scan_ctrl;

  localparam int unsigned ND = 4;
  localparam int unsigned SD = 4;

  typedef struct packed {
    logic [3:0] en;
    logic [3:0] bcd;
    logic       dp;
    logic       fs;
    logic       chk_bcd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b0;
  logic [15:0] value_in = '0;
  logic        value_valid = 1'b0;
  logic        lz_blank = 1'b0;
  logic [3:0]  dp_mask = '0;

  logic [3:0] bcd_a, bcd_b;
  logic       dp_a, dp_b;
  logic [3:0] en_a, en_b;
  logic       fs_a, fs_b;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .ena(ena), .value_in(value_in), .value_valid(value_valid),
    .lz_blank(lz_blank), .dp_mask(dp_mask), .bcd_out(bcd_a), .dp_out(dp_a),
    .digit_en(en_a), .frame_start(fs_a)
  );

  seg_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .ena(ena), .value_in(value_in), .value_valid(value_valid),
    .lz_blank(lz_blank), .dp_mask(dp_mask), .bcd_out(bcd_b), .dp_out(dp_b),
    .digit_en(en_b), .frame_start(fs_b)
  );

  // Reference model state, one slot per instance.
  bit          m_run[2];
  int unsigned m_t[2];
  logic [15:0] m_act[2];
  logic [15:0] m_pend[2];
  bit          m_pf[2];
  logic [3:0]  m_bcd[2];

  exp_t q_a[$];
  exp_t q_b[$];

  // One clock edge of the model: position in frame is a plain cycle count t.
  task automatic model_step(input int k, input int unsigned bc, output exp_t e);
    int unsigned slot_len, frame, slot, ph, hi;
    bit          bnd, lit;
    logic [3:0]  dig;
    slot_len = SD + bc;
    frame    = ND * slot_len;
    e        = '0;
    if (rst) begin
      m_run[k] = 0; m_t[k] = 0; m_act[k] = '0; m_pend[k] = '0; m_pf[k] = 0; m_bcd[k] = '0;
      e.chk_bcd = 1'b1;
      return;
    end
    bnd = 0;
    if (!ena) begin
      m_run[k] = 0; m_t[k] = 0;
    end else if (!m_run[k]) begin
      m_run[k] = 1; m_t[k] = 0; bnd = 1;
    end else begin
      m_t[k] = (m_t[k] + 1) % frame;
      bnd    = (m_t[k] == 0);
    end
    if (value_valid) begin
      m_pend[k] = value_in; m_pf[k] = 1;
    end
    if (bnd) begin
      if (value_valid) m_act[k] = value_in;
      else if (m_pf[k]) m_act[k] = m_pend[k];
      m_pf[k] = 0;
    end
    if (!m_run[k]) begin
      m_bcd[k]  = '0;
      e.chk_bcd = 1'b1;
      return;
    end
    slot = m_t[k] / slot_len;
    ph   = m_t[k] % slot_len;
    if (ph < SD) begin
      // Highest significant position: nonzero nibble or requested decimal point.
      hi = 0;
      for (int i = 0; i < ND; i++)
        if (m_act[k][i*4 +: 4] != 0 || dp_mask[i]) hi = i;
      lit      = !(lz_blank && slot > hi);
      dig      = m_act[k][slot*4 +: 4];
      m_bcd[k] = dig;
      e.bcd    = dig;
      e.en     = lit ? (4'b0001 << slot) : 4'b0000;
      e.dp     = lit && dp_mask[slot];
      e.fs     = (m_t[k] == 0);
      e.chk_bcd = lit;
    end else begin
      e.bcd = m_bcd[k];
    end
  endtask

  always @(posedge clk) begin
    exp_t ea, eb;
    model_step(0, 2, ea);
    model_step(1, 0, eb);
    q_a.push_back(ea);
    q_b.push_back(eb);
  end

  function automatic void chk(string name, int k, logic [3:0] act, logic [3:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d at %0t: got %0h, expected %0h", name, k, $time, act, exp);
  endfunction

  // Monitor: compare every registered output once per cycle, away from the edge.
  always @(negedge clk) begin
    exp_t e;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      chk("digit_en", 0, en_a, e.en);
      chk("dp_out", 0, {3'b0, dp_a}, {3'b0, e.dp});
      chk("frame_start", 0, {3'b0, fs_a}, {3'b0, e.fs});
      if (e.chk_bcd) chk("bcd_out", 0, bcd_a, e.bcd);
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      chk("digit_en", 1, en_b, e.en);
      chk("dp_out", 1, {3'b0, dp_b}, {3'b0, e.dp});
      chk("frame_start", 1, {3'b0, fs_b}, {3'b0, e.fs});
      if (e.chk_bcd) chk("bcd_out", 1, bcd_b, e.bcd);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic strobe(input logic [15:0] v);
    value_in    = v;
    value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
  endtask

  // Advance until instance 0 sits at frame position t (bounded).
  task automatic wait_pos(input int unsigned t);
    for (int n = 0; n < 200 && !(m_run[0] && m_t[0] == t); n++) tick();
  endtask

  initial begin
    bit ena_r;
    run(2);
    rst = 1'b0;
    ena = 1'b1;
    strobe(16'h1234);
    run(60);

    wait_pos(13);
    strobe(16'h5678);
    run(50);

    wait_pos(23);
    strobe(16'h9abc);
    run(30);

    lz_blank = 1'b1;
    strobe(16'h0045);
    run(50);
    strobe(16'h0000);
    run(50);
    dp_mask = 4'b0100;
    strobe(16'h0045);
    run(50);
    dp_mask  = 4'b0000;
    lz_blank = 1'b0;

    wait_pos(7);
    ena = 1'b0;
    run(3);
    ena = 1'b1;
    run(30);

    wait_pos(16);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run(30);

    ena_r = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 79) == 0) ena_r = ~ena_r;
      if (!ena_r && $urandom_range(0, 9) == 0) ena_r = 1'b1;
      ena = ena_r;
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 49) == 0) lz_blank = $urandom_range(0, 1);
      if ($urandom_range(0, 49) == 0) dp_mask = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
      value_valid = ($urandom_range(0, 14) == 0);
      value_in    = 16'($urandom) >> (4 * $urandom_range(0, 4));
      tick();
    end
    value_valid = 1'b0;
    rst = 1'b0;
    run(2);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexes one shared BCD-to-7-segment decoder across NUM_DIGITS common-cathode digits.
- Holds a frame-stable snapshot of the multi-digit BCD value and presents one nibble at a time on bcd_out, which feeds the decoder.
- Drives the one-hot digit enables with a dead-time between digits so no segment ghosts onto the next digit.
- Sits between the counter datapath (source of BCD digits) and the decoder/pad outputs.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; must be 2..8.
- SCAN_DIV, 1000: clock cycles each digit is shown (SHOW phase); must be >= 1.
- BLANK_CYCLES, 16: dead-time cycles with all digits off after each SHOW; 0 means no BLANK phase.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- ena  in  1  scan enable; 0 means all digits off
- value_in  in  4*NUM_DIGITS  BCD digits; nibble 0 is least significant
- value_valid  in  1  one-cycle strobe that captures value_in
- lz_blank  in  1  enables leading-zero blanking
- dp_mask  in  NUM_DIGITS  decimal point request per digit
- bcd_out  out  4  nibble to the shared decoder
- dp_out  out  1  decimal point for the currently shown digit
- digit_en  out  NUM_DIGITS  one-hot active-high digit enable, or all zero
- frame_start  out  1  one-cycle pulse at the start of each frame

Behaviour:
- Interface decision: one clock (clk); reset is synchronous and active-high (rst). All state updates on the rising edge of clk. All outputs are registered.
- Reset values:
  - state = IDLE, idx = 0, prescaler = 0.
  - pending, active and pend_flag = 0.
  - bcd_out = 0, dp_out = 0, digit_en = 0, frame_start = 0.
- Capture:
  - value_valid = 1 loads pending <= value_in and sets pend_flag.
  - At each frame boundary (entering SHOW with idx = 0), active <= pending if pend_flag = 1, and pend_flag clears.
  - If value_valid is high in the boundary cycle itself, value_in goes straight into active.
  - active never changes mid-frame, so there is no tearing.
- States:
  - IDLE: outputs are at reset values. When ena = 1, go to SHOW with idx = 0.
  - SHOW:
    - bcd_out = active[idx]; dp_out = dp_mask[idx]; digit_en = (1 << idx), unless idx is blanked.
    - Stays for exactly SCAN_DIV cycles, then goes to BLANK, or straight to the next SHOW if BLANK_CYCLES = 0.
  - BLANK: digit_en = 0 and dp_out = 0; bcd_out holds its value. Stays for BLANK_CYCLES cycles, then goes to the next SHOW.
- Digit sequencing:
  - The next SHOW uses idx + 1; after NUM_DIGITS-1, idx wraps to 0.
  - Frame length = NUM_DIGITS * (SCAN_DIV + BLANK_CYCLES) cycles.
- frame_start is high exactly on the first SHOW cycle of idx 0.
- Leading-zero blanking:
  - With lz_blank = 1, digit i is blanked if active[i] and all more-significant nibbles are 0.
  - Digit 0 is never blanked.
  - A blanked digit keeps its full time slot with digit_en = 0 and dp_out = 0, so scan timing is uniform.
  - A digit with dp_mask set is not blanked, and neither is any digit below it.
- ena:
  - Deasserting ena returns the block to IDLE on the next edge: outputs off, idx = 0, prescaler = 0.
  - Re-enabling starts a fresh frame, with frame_start pulsing.
  - pending capture continues while in IDLE.
- Mid-operation rst takes priority over every other input.
- Invalid nibbles (greater than 9) are passed through unchanged; the decoder shows them as "F".
- Prescaler width is clog2(max(SCAN_DIV, BLANK_CYCLES)).

Decomposition:
- Shared package seg_pkg holds:
  - scan state enum: IDLE, SHOW, BLANK
  - DIGIT_W = 4
  - segment constants
- Natural sub-module: seg_lz_mask. It is combinational: it takes active, lz_blank and dp_mask, and returns the NUM_DIGITS blank mask.
- The shared decoder is instantiated one level up, not inside this block.

Test Plan (NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=2 unless stated):
- Basic scan:
  - Stimulus: rst for 2 cycles, then ena=1 and value_valid with value_in=16'h1234.
  - Required: digit_en = 0001 for 4 cycles with bcd_out=4, then 0000 for 2 cycles, then 0010 with bcd_out=3, and so on.
  - Required: frame_start pulses every 24 cycles.
- Tear-free update:
  - Stimulus: value_valid with 16'h5678 during idx 2 of a frame.
  - Required: bcd_out for idx 3 is still 1; the next frame shows 8, 7, 6, 5.
- Boundary capture:
  - Stimulus: value_valid in the same cycle as frame_start.
  - Required: the new value is displayed in that frame's idx 0 slot.
- Leading zeros:
  - Stimulus: value=16'h0045, lz_blank=1.
  - Required: digit_en stays 0 during the idx 2 and idx 3 slots.
  - Stimulus: then value=16'h0000.
  - Required: only digit 0 is lit, with bcd_out=0.
  - Stimulus: then dp_mask=4'b0100 with value=16'h0045.
  - Required: idx 2 is lit with dp_out=1 and bcd_out=0.
- ena drop and reset:
  - Stimulus: ena=0 mid-SHOW of idx 1.
  - Required: the next cycle has digit_en=0.
  - Stimulus: re-enable.
  - Required: frame_start pulses, then digit_en=0001.
  - Stimulus: assert rst mid-BLANK.
  - Required: all outputs return to reset values on the next edge.
- Zero dead-time:
  - Stimulus: BLANK_CYCLES=0.
  - Required: digit_en steps 0001→0010→0100→1000 every 4 cycles with no all-zero gap; the frame is 16 cycles.
